// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file write scheduler.
//   PW             register address width (2**PW registers)
//   DW             register data width
//   wsched_state_t write-port FSM states
//   rf_src_t       write-port producers (A = ALU writeback, B = load return)
package rf_pkg;

   localparam int PW = 4;
   localparam int DW = 8;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      CHECK
   } wsched_state_t;

   typedef enum logic {
      SRC_A,
      SRC_B
   } rf_src_t;

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending-write bit per register, used to flag
// read-after-write hazards on the two register-file read ports.
//   clk, reset          clock, synchronous active-high reset
//   set_en, set_addr    reserve a destination (sets its pending bit)
//   clr_en, clr_addr    commit of a write (clears its pending bit)
//   rd_addr_a/b         read-port addresses
//   haz_a/b             combinational: addressed register has a pending write
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int pw = PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          set_en,
   input  logic [pw-1:0] set_addr,
   input  logic          clr_en,
   input  logic [pw-1:0] clr_addr,
   input  logic [pw-1:0] rd_addr_a,
   input  logic [pw-1:0] rd_addr_b,
   output logic          haz_a,
   output logic          haz_b
);

   localparam int NREG = 2 ** pw;

   logic [NREG-1:0] pending;

   // NOTE: the pending bits are control state, not data storage: they must
   // come out of reset cleared or the issue logic would stall on phantom hazards.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         // NOTE: non-blocking assignments; when both hit the same bit the
         // later one (the set) is the value that lands, giving set priority.
         if (clr_en) pending[clr_addr] <= 1'b0;
         if (set_en) pending[set_addr] <= 1'b1;
      end
   end

   assign haz_a = pending[rd_addr_a];
   assign haz_b = pending[rd_addr_b];

endmodule

// File: rtl/rf_write_sched.sv
// rf_write_sched: shares the register file's single write port between
// producer A (ALU writeback) and producer B (load return) with round-robin
// arbitration, and tracks pending writes for read-after-write hazards.
//   clk, reset                 clock, synchronous active-high reset
//   a_req/a_addr/a_data/a_gnt  producer A handshake (gnt pulses on accept)
//   b_req/b_addr/b_data/b_gnt  producer B handshake
//   rsv_en, rsv_addr           issue logic reserves a destination register
//   rd_addrA/B, hazA/B         read addresses and their hazard flags
//   rf_wr_en/addr, rf_dat_in   register-file write port (registered)
//   rf_done                    register-file write acknowledge
//   busy                       FSM not idle
//   err                        sticky: rf_done missing after a commit
module rf_write_sched
   import rf_pkg::*;
#(
   parameter int pw = PW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic [pw-1:0] a_addr,
   input  logic [DW-1:0] a_data,
   output logic          a_gnt,
   input  logic          b_req,
   input  logic [pw-1:0] b_addr,
   input  logic [DW-1:0] b_data,
   output logic          b_gnt,
   input  logic          rsv_en,
   input  logic [pw-1:0] rsv_addr,
   input  logic [pw-1:0] rd_addrA,
   input  logic [pw-1:0] rd_addrB,
   output logic          hazA,
   output logic          hazB,
   output logic          rf_wr_en,
   output logic [pw:0]   rf_wr_addr,
   output logic [DW-1:0] rf_dat_in,
   input  logic          rf_done,
   output logic          busy,
   output logic          err
);

   wsched_state_t state;
   rf_src_t       last_winner;
   logic          win_a;
   logic          win_b;

   // Grants are combinational so that gnt and req overlap in the accept cycle.
   // They are suppressed under reset because that edge will not accept anything.
   // NOTE: every output of this block gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      win_a = 1'b0;
      win_b = 1'b0;
      if (!reset && (state == IDLE || state == CHECK)) begin
         if (a_req && b_req) begin
            win_a = (last_winner == SRC_B);
            win_b = (last_winner == SRC_A);
         end else begin
            win_a = a_req;
            win_b = b_req;
         end
      end
   end

   assign a_gnt = win_a;
   assign b_gnt = win_b;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         last_winner <= SRC_B;
         rf_wr_en    <= 1'b0;
         rf_wr_addr  <= '0;
         rf_dat_in   <= '0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else begin
         rf_wr_en <= 1'b0;
         case (state)
            IDLE, CHECK: begin
               if (state == CHECK && !rf_done) err <= 1'b1;
               if (win_a || win_b) begin
                  state       <= WRITE;
                  busy        <= 1'b1;
                  rf_wr_en    <= 1'b1;
                  last_winner <= win_a ? SRC_A : SRC_B;
                  rf_wr_addr  <= {1'b0, (win_a ? a_addr : b_addr)};
                  rf_dat_in   <= win_a ? a_data : b_data;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            WRITE: begin
               state <= CHECK;
               busy  <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // The write commits on the edge that ends WRITE; that edge clears pending.
   rf_scoreboard #(.pw(pw)) u_scoreboard (
      .clk       (clk),
      .reset     (reset),
      .set_en    (rsv_en),
      .set_addr  (rsv_addr),
      .clr_en    (state == WRITE),
      .clr_addr  (rf_wr_addr[pw-1:0]),
      .rd_addr_a (rd_addrA),
      .rd_addr_b (rd_addrB),
      .haz_a     (hazA),
      .haz_b     (hazB)
   );

endmodule

// File: tb/tb_rf_write_sched.sv
// tb_rf_write_sched: scoreboard bench for rf_write_sched. A cycle model of
// the scheduler's rules predicts grants, busy, err and the pending bits; each
// predicted grant pushes the expected write into a queue that a separate
// monitor pops whenever the DUT drives rf_wr_en.
module tb_rf_write_sched;
   import rf_pkg::*;

   logic          clk;
   logic          reset;
   logic          a_req, b_req;
   logic [PW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_data, b_data;
   logic          a_gnt, b_gnt;
   logic          rsv_en;
   logic [PW-1:0] rsv_addr;
   logic [PW-1:0] rd_addrA, rd_addrB;
   logic          hazA, hazB;
   logic          rf_wr_en;
   logic [PW:0]   rf_wr_addr;
   logic [DW-1:0] rf_dat_in;
   logic          rf_done;
   logic          busy, err;

   rf_write_sched #(.pw(PW)) dut (
      .clk        (clk),
      .reset      (reset),
      .a_req      (a_req),
      .a_addr     (a_addr),
      .a_data     (a_data),
      .a_gnt      (a_gnt),
      .b_req      (b_req),
      .b_addr     (b_addr),
      .b_data     (b_data),
      .b_gnt      (b_gnt),
      .rsv_en     (rsv_en),
      .rsv_addr   (rsv_addr),
      .rd_addrA   (rd_addrA),
      .rd_addrB   (rd_addrB),
      .hazA       (hazA),
      .hazB       (hazB),
      .rf_wr_en   (rf_wr_en),
      .rf_wr_addr (rf_wr_addr),
      .rf_dat_in  (rf_dat_in),
      .rf_done    (rf_done),
      .busy       (busy),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file stand-in: no reset, done acknowledges the previous cycle's write.
   logic [DW-1:0] mem [2**PW];
   logic          done_q = 1'b0;
   logic          drop_done;
   always @(posedge clk) begin
      if (rf_wr_en) mem[rf_wr_addr[PW-1:0]] <= rf_dat_in;
      done_q <= rf_wr_en;
   end
   assign rf_done = done_q && !drop_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [PW-1:0] addr;
      logic [DW-1:0] data;
      int            cyc;
   } wr_t;
   typedef struct {
      bit src;
      int cyc;
   } gnt_t;

   wr_t  exp_q [$];
   gnt_t glog  [$];

   // Reference model state
   bit            chk_on = 1'b0;
   bit            m_grant_prev = 1'b0;
   bit            m_write_prev = 1'b0;
   bit            m_last_b = 1'b1;
   bit            m_err = 1'b0;
   bit            m_pend [2**PW];
   logic [PW-1:0] m_wr_addr = '0;

   always @(negedge clk) begin
      bit in_write, in_check, window, ga, gb;
      if (chk_on) begin
         in_write = m_grant_prev;
         in_check = m_write_prev;
         window   = !in_write && !reset;
         ga = 1'b0;
         gb = 1'b0;
         if (window) begin
            if (a_req && b_req) begin
               ga = m_last_b;
               gb = !m_last_b;
            end else begin
               ga = a_req;
               gb = b_req;
            end
         end
         check("a_gnt", a_gnt, ga);
         check("b_gnt", b_gnt, gb);
         check("wr_en", rf_wr_en, in_write);
         check("busy", busy, in_write || in_check);
         check("err", err, m_err);
         check("hazA", hazA, m_pend[rd_addrA]);
         check("hazB", hazB, m_pend[rd_addrB]);

         if (a_gnt) glog.push_back('{1'b0, cyc});
         if (b_gnt) glog.push_back('{1'b1, cyc});
         if (ga) begin
            exp_q.push_back('{a_addr, a_data, cyc});
            m_wr_addr = a_addr;
         end
         if (gb) begin
            exp_q.push_back('{b_addr, b_data, cyc});
            m_wr_addr = b_addr;
         end

         if (reset) begin
            m_pend       = '{default: 1'b0};
            m_last_b     = 1'b1;
            m_err        = 1'b0;
            m_grant_prev = 1'b0;
            m_write_prev = 1'b0;
         end else begin
            if (in_check && !rf_done) m_err = 1'b1;
            if (in_write) m_pend[m_wr_addr] = 1'b0;
            if (rsv_en) m_pend[rsv_addr] = 1'b1;
            if (ga) m_last_b = 1'b0;
            if (gb) m_last_b = 1'b1;
            m_grant_prev = ga || gb;
            m_write_prev = in_write;
         end
      end
   end

   // Monitor: every write the DUT presents must match the oldest accepted request.
   always @(negedge clk) begin
      wr_t e;
      if (chk_on && rf_wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("wr_addr", rf_wr_addr, {1'b0, e.addr});
            check("wr_data", rf_dat_in, e.data);
            check("wr_latency", cyc - e.cyc, 1);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      a_req = 1'b0; b_req = 1'b0; rsv_en = 1'b0; drop_done = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic run_prod(input bit is_b, input int n);
      int            idle, waited;
      bit            got;
      logic [PW-1:0] ad;
      logic [DW-1:0] dt;
      @(posedge clk); #1;
      for (int i = 0; i < n; i++) begin
         idle = $urandom_range(0, 2);
         if (idle > 0) begin
            if (is_b) b_req = 1'b0; else a_req = 1'b0;
            repeat (idle) @(posedge clk);
            #1;
         end
         ad = PW'($urandom);
         dt = DW'($urandom);
         if (is_b) begin b_req = 1'b1; b_addr = ad; b_data = dt; end
         else      begin a_req = 1'b1; a_addr = ad; a_data = dt; end
         waited = 0;
         got    = 1'b0;
         while (!got && waited < 8) begin
            @(negedge clk);
            waited++;
            got = is_b ? b_gnt : a_gnt;
            @(posedge clk); #1;
         end
         check(is_b ? "b_wait_le4" : "a_wait_le4", (got && waited <= 4), 1'b1);
      end
      if (is_b) b_req = 1'b0; else a_req = 1'b0;
   endtask

   task automatic run_rsv(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rsv_en   = ($urandom_range(0, 3) == 0);
         rsv_addr = PW'($urandom);
         rd_addrA = PW'($urandom);
         rd_addrB = PW'($urandom);
      end
      rsv_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      a_req = 1'b0; a_addr = '0; a_data = '0;
      b_req = 1'b0; b_addr = '0; b_data = '0;
      rsv_en = 1'b0; rsv_addr = '0; rd_addrA = '0; rd_addrB = '0;
      drop_done = 1'b0;
      @(posedge clk); #1;
      chk_on = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_wr_en", rf_wr_en, 1'b0);
      check("rst_wr_addr", rf_wr_addr, 5'h00);
      check("rst_dat_in", rf_dat_in, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_gnt", {a_gnt, b_gnt}, 2'b00);

      // Single write: A writes r3 = 0x5A
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = 4'd3; a_data = 8'h5A;
      @(negedge clk);
      check("t1_a_gnt", a_gnt, 1'b1);
      @(posedge clk); #1;
      a_req = 1'b0;
      @(negedge clk);
      check("t1_wr_en", rf_wr_en, 1'b1);
      check("t1_wr_addr", rf_wr_addr, 5'h03);
      check("t1_dat_in", rf_dat_in, 8'h5A);
      @(negedge clk);
      check("t1_done", rf_done, 1'b1);
      check("t1_err", err, 1'b0);
      check("t1_mem", mem[3], 8'h5A);

      // Both producers request continuously from reset: A, B, A, B, 2 cycles apart
      do_reset();
      glog.delete();
      a_req = 1'b1; a_addr = 4'd1; a_data = 8'h11;
      b_req = 1'b1; b_addr = 4'd2; b_data = 8'h22;
      repeat (12) @(posedge clk);
      #1;
      a_req = 1'b0; b_req = 1'b0;
      repeat (3) @(posedge clk);
      check("t2_grants", glog.size(), 6);
      for (int i = 0; i < glog.size(); i++) begin
         check("t2_order", glog[i].src, i % 2);
         if (i > 0) check("t2_spacing", glog[i].cyc - glog[i-1].cyc, 2);
      end

      // Reserve r7 at t, hazard from t+1; B writes r7 granted at t+3, hazard gone at t+5
      #1;
      rsv_en = 1'b1; rsv_addr = 4'd7; rd_addrA = 4'd7;
      @(posedge clk); #1;
      rsv_en = 1'b0;
      @(negedge clk);
      check("t3_haz_t1", hazA, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_haz_t2", hazA, 1'b1);
      @(posedge clk); #1;
      b_req = 1'b1; b_addr = 4'd7; b_data = 8'h77;
      @(negedge clk);
      check("t3_b_gnt", b_gnt, 1'b1);
      @(posedge clk); #1;
      b_req = 1'b0;
      @(negedge clk);
      check("t3_haz_t4", hazA, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t3_haz_t5", hazA, 1'b0);
      check("t3_mem", mem[7], 8'h77);

      // Reserve of r7 on the same edge that commits r7: set wins
      @(posedge clk); #1;
      b_req = 1'b1; b_addr = 4'd7; b_data = 8'h99;
      @(negedge clk);
      check("t4_b_gnt", b_gnt, 1'b1);
      @(posedge clk); #1;
      b_req = 1'b0; rsv_en = 1'b1; rsv_addr = 4'd7;
      @(posedge clk); #1;
      rsv_en = 1'b0;
      @(negedge clk);
      check("t4_haz_kept", hazA, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_haz_still", hazA, 1'b1);

      // Missing rf_done in CHECK raises a sticky err
      @(posedge clk); #1;
      a_req = 1'b1; a_addr = 4'd5; a_data = 8'hC3;
      @(posedge clk); #1;
      a_req = 1'b0;
      @(posedge clk); #1;
      drop_done = 1'b1;
      @(negedge clk);
      check("t5_err_before", err, 1'b0);
      @(posedge clk); #1;
      drop_done = 1'b0;
      @(negedge clk);
      check("t5_err_set", err, 1'b1);
      @(posedge clk); #1;
      b_req = 1'b1; b_addr = 4'd6; b_data = 8'h66;
      @(posedge clk); #1;
      b_req = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("t5_err_sticky", err, 1'b1);

      // Reset asserted during WRITE
      @(posedge clk); #1;
      rsv_en = 1'b1; rsv_addr = 4'd4;
      @(posedge clk); #1;
      rsv_addr = 4'd9;
      @(posedge clk); #1;
      rsv_en = 1'b0; rd_addrA = 4'd4; rd_addrB = 4'd9;
      a_req = 1'b1; a_addr = 4'd2; a_data = 8'h42;
      @(negedge clk);
      check("t6_a_gnt", a_gnt, 1'b1);
      check("t6_hazA_pre", hazA, 1'b1);
      check("t6_hazB_pre", hazB, 1'b1);
      @(posedge clk); #1;
      a_req = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("t6_wr_en_in_write", rf_wr_en, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("t6_wr_en_off", rf_wr_en, 1'b0);
      check("t6_hazA", hazA, 1'b0);
      check("t6_hazB", hazB, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_err", err, 1'b0);

      // Randomized traffic against the model
      fork
         run_prod(1'b0, 40);
         run_prod(1'b1, 40);
         run_rsv(300);
      join
      repeat (6) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
